// File: rtl/rx_payload_packer_ble_if.sv
// Handshake/bus bundle between the Hamming-decoded bit stream, the packer and the byte consumer.
// The master modport is the side that feeds bits and accepts bytes.
interface rx_payload_packer_ble_if;
    logic       valid_in;
    logic       data_in;
    logic       err_in;
    logic       byte_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       packet_done;
    logic       crc_ok;
    logic       fec_err;
    logic       overflow;

    modport master (
        output valid_in, data_in, err_in, byte_ready,
        input  byte_out, byte_valid, packet_done, crc_ok, fec_err, overflow
    );

    modport slave (
        input  valid_in, data_in, err_in, byte_ready,
        output byte_out, byte_valid, packet_done, crc_ok, fec_err, overflow
    );
endinterface

// File: rtl/rx_payload_packer_ble.sv
// BLE RX payload packer: packs decoded bits into length/payload bytes, checks the
// trailing CRC-24 and queues the bytes in a small output FIFO.
module rx_payload_packer_ble #(
    parameter logic [23:0] CRC_INIT   = 24'h555555,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    rx_payload_packer_ble_if.slave  bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CRC, DONE} state_t;

    state_t      state_q;
    logic [7:0]  sr_q, len_q, byte_cnt_q, push_data_q;
    logic [2:0]  bit_cnt_q;
    logic [4:0]  crc_idx_q;
    logic [23:0] crc_q;
    logic        match_q, push_q, done_q, crc_ok_q, fec_err_q, overflow_q;

    logic [7:0]  sr_d;
    logic [23:0] crc_base, crc_d;
    logic        fb, crc_bit_ok, byte_done;

    logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    head_q, head_d;
    logic          pop, full, push_ok, drop;

    // The first bit of a packet is applied on top of the preset, not the stale register.
    always_comb begin
        sr_d       = {bus.data_in, sr_q[7:1]};
        crc_base   = (state_q == IDLE) ? CRC_INIT : crc_q;
        fb         = crc_base[23] ^ bus.data_in;
        crc_d      = {crc_base[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
        crc_bit_ok = (bus.data_in == crc_q[5'd23 - crc_idx_q]);
        byte_done  = (bit_cnt_q == 3'd7);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            crc_idx_q   <= '0;
            crc_q       <= '0;
            match_q     <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            fec_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            done_q <= 1'b0;
            if (drop) overflow_q <= 1'b1;
            if (bus.err_in && state_q != IDLE) fec_err_q <= 1'b1;
            case (state_q)
                IDLE: if (bus.valid_in) begin
                    state_q    <= LEN;
                    crc_q      <= crc_d;
                    sr_q       <= sr_d;
                    bit_cnt_q  <= 3'd1;
                    byte_cnt_q <= '0;
                    crc_idx_q  <= '0;
                    match_q    <= 1'b1;
                    crc_ok_q   <= 1'b0;
                    fec_err_q  <= 1'b0;
                    overflow_q <= 1'b0;
                end
                LEN: if (bus.valid_in) begin
                    crc_q     <= crc_d;
                    sr_q      <= sr_d;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        len_q       <= sr_d;
                        push_q      <= 1'b1;
                        push_data_q <= sr_d;
                        state_q     <= (sr_d != 8'd0) ? PAYLOAD : CRC;
                    end
                end
                PAYLOAD: if (bus.valid_in) begin
                    crc_q     <= crc_d;
                    sr_q      <= sr_d;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        push_q      <= 1'b1;
                        push_data_q <= sr_d;
                        byte_cnt_q  <= byte_cnt_q + 8'd1;
                        if (byte_cnt_q + 8'd1 == len_q) state_q <= CRC;
                    end
                end
                CRC: if (bus.valid_in) begin
                    crc_idx_q <= crc_idx_q + 5'd1;
                    if (!crc_bit_ok) match_q <= 1'b0;
                    if (crc_idx_q == 5'd23) begin
                        state_q  <= DONE;
                        crc_ok_q <= match_q && crc_bit_ok;
                        done_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pop     = (cnt_q != '0) && bus.byte_ready;
    assign full    = (cnt_q == FULL_CNT);
    assign push_ok = push_q && (!full || pop);
    assign drop    = push_q && full && !pop;

    // head_q mirrors the entry at rd_q so byte_out comes straight from a flop.
    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (push_ok) begin
            mem_d[wr_q] = push_data_q;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) rd_d = rd_q + AW'(1);
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (pop && cnt_q > 1)
            head_d = mem_q[rd_q + AW'(1)];
        else if (push_ok && (cnt_q == '0 || (pop && cnt_q == 1)))
            head_d = push_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    assign bus.byte_out    = head_q;
    assign bus.byte_valid  = (cnt_q != '0);
    assign bus.packet_done = done_q;
    assign bus.crc_ok      = crc_ok_q;
    assign bus.fec_err     = fec_err_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_rx_payload_packer_ble.sv
// Directed bench for rx_payload_packer_ble: normal, bad-CRC, empty, overflow,
// gapped/FEC-error and mid-packet-reset packets.
module tb_rx_payload_packer_ble;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rx_payload_packer_ble_if ifc();
    rx_payload_packer_ble #(.CRC_INIT(24'h555555), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bus(ifc)
    );

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  got[$];
    int          done_cnt = 0;
    logic        crc_ok_at, fec_at, ovf_at;
    logic [23:0] mcrc;
    int          d0;

    always @(posedge clk) begin
        if (ifc.byte_valid && ifc.byte_ready) got.push_back(ifc.byte_out);
        if (ifc.packet_done) begin
            done_cnt++;
            crc_ok_at = ifc.crc_ok;
            fec_at    = ifc.fec_err;
            ovf_at    = ifc.overflow;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        checks++;
        assert (obs === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expected);
        end
    endtask

    task automatic send_bit(input logic b, input int maxgap);
        ifc.valid_in = 1'b1;
        ifc.data_in  = b;
        @(negedge clk);
        ifc.valid_in = 1'b0;
        ifc.data_in  = 1'b0;
        if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        for (int i = 0; i < 8; i++) begin
            logic f;
            f    = mcrc[23] ^ b[i];
            mcrc = {mcrc[22:0], 1'b0} ^ (f ? 24'h00065B : 24'h000000);
            send_bit(b[i], maxgap);
        end
    endtask

    task automatic send_crc(input int flip, input int maxgap);
        for (int k = 0; k < 24; k++) send_bit(mcrc[23-k] ^ (k == flip), maxgap);
    endtask

    task automatic start_pkt();
        mcrc = 24'h555555;
        got.delete();
        d0 = done_cnt;
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < 60 && got.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_q(input string tag, input int n, input logic [63:0] expected);
        chk({tag, " byte count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk($sformatf("%s byte[%0d]", tag, i), {24'h0, got[i]}, {24'h0, expected[8*i +: 8]});
    endtask

    initial begin
        reset          = 1'b1;
        ifc.valid_in   = 1'b0;
        ifc.data_in    = 1'b0;
        ifc.err_in     = 1'b0;
        ifc.byte_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst byte_out",    ifc.byte_out, 0);
        chk("rst byte_valid",  ifc.byte_valid, 0);
        chk("rst packet_done", ifc.packet_done, 0);
        chk("rst crc_ok",      ifc.crc_ok, 0);
        chk("rst fec_err",     ifc.fec_err, 0);
        chk("rst overflow",    ifc.overflow, 0);
        reset = 1'b0;
        @(negedge clk);

        // L=2 good packet, with a latency probe on the length byte
        ifc.byte_ready = 1'b1;
        start_pkt();
        send_byte(8'h02, 0);
        @(negedge clk);
        chk("t1 latency valid", ifc.byte_valid, 1);
        chk("t1 latency byte",  ifc.byte_out, 8'h02);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_crc(-1, 0);
        wait_drain(3);
        chk_q("t1", 3, 64'h3CA502);
        chk("t1 done pulses", done_cnt - d0, 1);
        chk("t1 crc_ok", crc_ok_at, 1);
        chk("t1 fec_err", fec_at, 0);
        chk("t1 crc_ok held", ifc.crc_ok, 1);

        // Same packet with one CRC bit inverted
        start_pkt();
        send_byte(8'h02, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_crc(5, 0);
        wait_drain(3);
        chk_q("t2", 3, 64'h3CA502);
        chk("t2 done pulses", done_cnt - d0, 1);
        chk("t2 crc_ok", crc_ok_at, 0);

        // Empty payload goes straight to CRC
        start_pkt();
        send_byte(8'h00, 0);
        send_crc(-1, 0);
        wait_drain(1);
        chk_q("t3", 1, 64'h00);
        chk("t3 done pulses", done_cnt - d0, 1);
        chk("t3 crc_ok", crc_ok_at, 1);

        // L=6 into a 4-deep FIFO with no consumer
        ifc.byte_ready = 1'b0;
        start_pkt();
        send_byte(8'h06, 0);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        send_byte(8'h30, 0);
        send_byte(8'h40, 0);
        send_byte(8'h50, 0);
        send_byte(8'h60, 0);
        send_crc(-1, 0);
        repeat (3) @(negedge clk);
        chk("t4 done pulses", done_cnt - d0, 1);
        chk("t4 overflow at done", ovf_at, 1);
        chk("t4 crc_ok", crc_ok_at, 1);
        chk("t4 byte_valid", ifc.byte_valid, 1);
        chk("t4 no pops", got.size(), 0);
        ifc.byte_ready = 1'b1;
        wait_drain(4);
        chk_q("t4", 4, 64'h30201006);
        chk("t4 overflow held", ifc.overflow, 1);
        chk("t4 drained", ifc.byte_valid, 0);

        // Gapped bits with an FEC error pulse mid-payload
        start_pkt();
        send_byte(8'h03, 3);
        send_byte(8'h11, 3);
        ifc.err_in = 1'b1;
        @(negedge clk);
        ifc.err_in = 1'b0;
        send_byte(8'h22, 3);
        send_byte(8'h33, 3);
        send_crc(-1, 3);
        wait_drain(4);
        chk_q("t5", 4, 64'h33221103);
        chk("t5 done pulses", done_cnt - d0, 1);
        chk("t5 crc_ok", crc_ok_at, 1);
        chk("t5 fec_err", fec_at, 1);
        chk("t5 overflow cleared", ifc.overflow, 0);

        // Reset 13 bits into an L=4 payload, then a clean L=1 packet
        ifc.byte_ready = 1'b0;
        start_pkt();
        send_byte(8'h04, 0);
        for (int i = 0; i < 13; i++) send_bit(i[0], 0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6 rst byte_valid", ifc.byte_valid, 0);
        chk("t6 rst byte_out", ifc.byte_out, 0);
        reset = 1'b0;
        @(negedge clk);
        ifc.byte_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6 nothing out", got.size(), 0);
        chk("t6 no done", done_cnt - d0, 0);
        start_pkt();
        send_byte(8'h01, 0);
        send_byte(8'h9E, 0);
        send_crc(-1, 0);
        wait_drain(2);
        chk_q("t6", 2, 64'h9E01);
        chk("t6 done pulses", done_cnt - d0, 1);
        chk("t6 crc_ok", crc_ok_at, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_payload_packer_ble.md
RX_PAYLOAD_PACKER_BLE -- requirements
Module: rx_payload_packer_ble

Interface
REQ-001 Parameter CRC_INIT, default 24'h555555, CRC-24 preset value loaded at each packet start.
REQ-002 Parameter FIFO_DEPTH, default 4, number of entries in the output byte FIFO (power of two, >=2).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 valid_in  input  1  qualifies data_in; one decoded bit per cycle high.
REQ-007 data_in  input  1  decoded payload bit from the Hamming decoder, LSB of each byte first.
REQ-008 err_in  input  1  uncorrectable-codeword flag from the Hamming decoder; any cycle high is significant.
REQ-009 byte_ready  input  1  downstream accepts byte_out this cycle.
REQ-010 byte_out  output  8  FIFO head byte.
REQ-011 byte_valid  output  1  FIFO non-empty.
REQ-012 packet_done  output  1  one-cycle pulse when the last CRC bit is consumed.
REQ-013 crc_ok  output  1  received CRC matched computed CRC; held until the next packet starts.
REQ-014 fec_err  output  1  err_in seen during the packet; held until the next packet starts.
REQ-015 overflow  output  1  at least one byte dropped because the FIFO was full; held until the next packet starts.

Function
REQ-016 FSM states SHALL be IDLE, LEN, PAYLOAD, CRC, DONE.
REQ-017 IDLE->LEN on the first valid_in; that bit is bit 0 of the length byte.
- On this transition: crc_reg loads CRC_INIT before the bit is applied, and crc_ok, fec_err and overflow clear.
REQ-018 Bits pack LSB first into a shift register with a 3-bit bit counter; a byte completes on the 8th valid bit.
REQ-019 LEN: on byte completion, latch len=L and push L to the FIFO.
- Go to PAYLOAD if L>0.
- Go to CRC if L==0.
REQ-020 PAYLOAD: push each completed byte; a 8-bit byte counter counts to L, then go to CRC.
REQ-021 CRC update per valid bit in LEN and PAYLOAD: fb=crc_reg[23]^bit; crc_reg={crc_reg[22:0],1'b0}^(fb?24'h00065B:0).
REQ-022 CRC: crc_reg freezes; the k-th received bit (k=0..23) is compared with crc_reg[23-k]; any mismatch clears a match flag.
- CRC bits are not pushed to the FIFO.
REQ-023 After the 24th CRC bit: go to DONE.
- crc_ok = match flag.
- packet_done pulses for one cycle.
REQ-024 DONE returns to IDLE on the next cycle; a valid_in in that cycle is ignored.
REQ-025 Cycles without valid_in SHALL NOT advance bit, byte or CRC counters in any state.
REQ-026 err_in high in any of LEN, PAYLOAD, CRC or DONE sets fec_err; err_in in IDLE is ignored.
REQ-027 FIFO push happens in the cycle after byte completion; pop happens on byte_valid&&byte_ready.
- byte_out is the registered head, valid while byte_valid is high.
REQ-028 Push into a full FIFO with a simultaneous pop SHALL be accepted.
REQ-029 Push into a full FIFO without a pop SHALL drop the byte and set overflow; FSM counting continues unaffected.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL never exceed FIFO_DEPTH.
REQ-031 Latency: a completed byte appears on byte_out with byte_valid high no later than 2 cycles after its 8th bit's valid_in (FIFO empty).

Reset
REQ-032 Reset SHALL force:
- FSM to IDLE.
- All counters, crc_reg, FIFO pointers and occupancy to 0.
- byte_out=8'h00, byte_valid=0, packet_done=0, crc_ok=0, fec_err=0, overflow=0.
REQ-033 Reset asserted mid-packet SHALL discard the partial byte and all FIFO contents; no packet_done is issued.

Verification
REQ-034 L=2, payload 0xA5,0x3C, model-correct CRC, byte_ready=1 -> bytes 0x02,0xA5,0x3C out; packet_done once; crc_ok=1; fec_err=0.
REQ-035 Same packet with one CRC bit inverted -> identical bytes; crc_ok=0 at packet_done.
REQ-036 L=0 with model-correct CRC -> single byte 0x00 output; CRC state entered directly; crc_ok=1.
REQ-037 L=6, byte_ready=0 throughout, FIFO_DEPTH=4 -> first 4 bytes retained, overflow=1; after draining, bytes are 0x06 and the first 3 payload bytes.
REQ-038 err_in pulsed mid-payload; valid_in gapped randomly 0-3 idle cycles between bits -> bytes and crc_ok unaffected by gaps; fec_err=1.
REQ-039 Reset asserted after 13 payload bits of an L=4 packet, then a clean L=1 packet -> only the L=1 packet's bytes appear; crc_ok=1.
